rgb2ycbcr_cfg: RTL and testbench
================================

RGB2YCBCR_CFG -- requirements
Module: rgb2ycbcr_cfg

Interface
REQ-001 SHALL have parameter R_W, default 5, red input width, legal 4..8.
REQ-002 SHALL have parameter G_W, default 6, green input width, legal 4..8.
REQ-003 SHALL have parameter B_W, default 5, blue input width, legal 4..8.
REQ-004 clk  in  1  module clock; one clock; all state on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 ce  in  1  pipeline advance enable.
REQ-007 pre_frame_vsync / pre_frame_hsync / pre_frame_de  in  1 each  input sync and data enable.
REQ-008 img_red / img_green / img_blue  in  R_W / G_W / B_W  input pixel.
REQ-009 std_sel  in  1  requested standard: 0 = BT.601, 1 = BT.709.
REQ-010 range_sel  in  1  requested range: 0 = full, 1 = limited.
REQ-011 post_frame_vsync / post_frame_hsync / post_frame_de  out  1 each  delayed sync and data enable.
REQ-012 img_y / img_cb / img_cr  out  8 each  output pixel.
REQ-013 std_act / range_act  out  1 each  mode in force for the current frame.

Function
REQ-014 Expansion SHALL be by MSB replication to 8 bits: x8 = {x, x[W-1 -: 8-W]}; W = 8 passes unchanged.
REQ-015 Coefficients (Q8): BT.601 Y = 77R + 150G + 29B, Cb = -43R - 85G + 128B, Cr = 128R - 107G - 21B.
REQ-016 Coefficients (Q8): BT.709 Y = 54R + 183G + 19B, Cb = -29R - 99G + 128B, Cr = 128R - 116G - 12B.
REQ-017 Full range SHALL compute Yf = (sumY + 128) >> 8 and Cf = (sumC + 32768 + 128) >> 8, in signed arithmetic of at least 18 bits, clamped to 0..255.
REQ-018 Limited range SHALL compute Y = 16 + ((Yf*220 + 128) >> 8) and C = 128 + (((Cf - 128)*225 + 128) >>> 8) (arithmetic shift), giving Y in 16..235 and C in 16..240.
REQ-019 Pipeline SHALL be 4 register stages:
- S1: expand and multiply.
- S2: sum, round, clamp.
- S3: range scaling, or pass-through in full range.
- S4: offset and output register.
REQ-020 Latency SHALL be exactly 4 ce-enabled cycles from input sample to output.
REQ-021 vsync, hsync and de SHALL be delayed through 4 ce-qualified stages so they stay aligned with pixel data.
REQ-022 ce = 0 SHALL hold every pipeline, sync and mode register unchanged; outputs stay static.
REQ-023 When post_frame_de = 0, img_y/img_cb/img_cr SHALL be 0; when post_frame_de = 1 they carry the computed value.
REQ-024 Mode registers SHALL load std_sel/range_sel only on a ce cycle where pre_frame_vsync = 1 and its previous sampled value = 0 (rising edge).
REQ-025 The new mode SHALL apply from that same input sample onward.
REQ-026 Mode changes at any other time SHALL be ignored; pixels already in the pipeline complete in the mode they entered with (mode travels with data through S1..S3).
REQ-027 A vsync held high for multiple cycles SHALL load mode only once.
REQ-028 Simultaneous vsync rising edge and ce = 0 SHALL NOT load mode.

Reset
REQ-029 During rst_n = 0 all outputs, pipeline registers, sync delays and the vsync edge register SHALL be 0, and std_act = range_act = 0.
REQ-030 Reset asserted mid-frame SHALL discard in-flight pixels; after release, outputs stay 0 until valid data has propagated 4 ce cycles.

Verification
REQ-031 Default params, BT.601 full, de = 1, RGB565 (31,63,31) -> 4 cycles later Y = 255, Cb = 128, Cr = 128.
REQ-032 BT.601 full, (31,0,0) -> Y = 77, Cb = 85, Cr = 255 (clamp exercised); BT.709 full -> Y = 54, Cb = 99, Cr = 255.
REQ-033 Limited range: white -> Y = 235, Cb = Cr = 128; black -> Y = 16, Cb = Cr = 128; pure blue BT.601 -> Cb = 240.
REQ-034 Toggle std_sel mid-frame -> no output change; after the next vsync rising edge, std_act = 1 and BT.709 values appear on pixels entering after the edge.
REQ-035 ce low for 3 cycles with a pixel stream -> output sequence identical to the ce = 1 run, stretched by 3 cycles; de gating yields zeros on blanking.
REQ-036 Parameter sweep: R_W = G_W = B_W = 8 and 4, max input -> Y = 255; assert rst_n mid-stream -> all outputs 0 immediately, modes back to 0.

Source files
------------

// File: rtl/rgb2ycbcr_cfg.sv
// rgb2ycbcr_cfg: converts RGB pixels to YCbCr with a frame-synchronous choice of
// standard (BT.601 / BT.709) and range (full / limited).
// The pipeline has four stages: expand+multiply, sum+round+clamp, range scale,
// and offset+output.
// The ce input advances the whole pipeline, and the sync signals travel alongside
// the pixel data.
// Legal input widths are 4..8 bits per channel.
module rgb2ycbcr_cfg #(
  parameter int R_W = 5,
  parameter int G_W = 6,
  parameter int B_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           pre_frame_vsync,
  input  logic           pre_frame_hsync,
  input  logic           pre_frame_de,
  input  logic [R_W-1:0] img_red,
  input  logic [G_W-1:0] img_green,
  input  logic [B_W-1:0] img_blue,
  input  logic           std_sel,
  input  logic           range_sel,
  output logic           post_frame_vsync,
  output logic           post_frame_hsync,
  output logic           post_frame_de,
  output logic [7:0]     img_y,
  output logic [7:0]     img_cb,
  output logic [7:0]     img_cr,
  output logic           std_act,
  output logic           range_act
);

  // Q8 coefficients. Rows are Y, Cb, Cr and columns are R, G, B.
  localparam logic signed [8:0] C601_YR =  9'sd77,  C601_YG =  9'sd150, C601_YB =  9'sd29;
  localparam logic signed [8:0] C601_BR = -9'sd43,  C601_BG = -9'sd85,  C601_BB =  9'sd128;
  localparam logic signed [8:0] C601_RR =  9'sd128, C601_RG = -9'sd107, C601_RB = -9'sd21;
  localparam logic signed [8:0] C709_YR =  9'sd54,  C709_YG =  9'sd183, C709_YB =  9'sd19;
  localparam logic signed [8:0] C709_BR = -9'sd29,  C709_BG = -9'sd99,  C709_BB =  9'sd128;
  localparam logic signed [8:0] C709_RR =  9'sd128, C709_RG = -9'sd116, C709_RB = -9'sd12;

  // Stage 1 holds the signed partial products.
  // sync is {vsync, hsync, de}, and rng is the range mode that travels with the pixel.
  typedef struct packed {
    logic [2:0]  sync;
    logic        rng;
    logic [17:0] yr, yg, yb;
    logic [17:0] br, bg, bb;
    logic [17:0] rr, rg, rb;
  } s1_t;

  // Stage 2 holds full-range values that are already clamped to 0..255.
  typedef struct packed {
    logic [2:0] sync;
    logic       rng;
    logic [7:0] yf, cbf, crf;
  } s2_t;

  // Stage 3 holds range-scaled values before the offset is added.
  // Chroma is stored as 9-bit two's complement.
  typedef struct packed {
    logic [2:0] sync;
    logic       rng;
    logic [7:0] ys;
    logic [8:0] cbs, crs;
  } s3_t;

  // Stage 4 is the output register.
  typedef struct packed {
    logic [2:0] sync;
    logic [7:0] y, cb, cr;
  } s4_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  s4_t  s4_d, s4_q;
  logic vs_prev_d, vs_prev_q;
  logic std_act_d, std_act_q;
  logic range_act_d, range_act_q;
  logic mode_load, std_cur, rng_cur;
  logic [7:0] r8, g8, b8;

  // Widen each channel to 8 bits by repeating its top bits into the vacated LSBs.
  if (R_W == 8) begin : g_r_pass
    assign r8 = img_red;
  end else begin : g_r_exp
    assign r8 = {img_red, img_red[R_W-1 -: 8-R_W]};
  end
  if (G_W == 8) begin : g_g_pass
    assign g8 = img_green;
  end else begin : g_g_exp
    assign g8 = {img_green, img_green[G_W-1 -: 8-G_W]};
  end
  if (B_W == 8) begin : g_b_pass
    assign b8 = img_blue;
  end else begin : g_b_exp
    assign b8 = {img_blue, img_blue[B_W-1 -: 8-B_W]};
  end

  // Unsigned 8-bit sample times a signed Q8 coefficient gives an 18-bit signed product.
  function automatic logic [17:0] mul(input logic [7:0] x, input logic signed [8:0] c);
    logic signed [17:0] p;
    p = $signed({1'b0, x}) * c;
    return p;
  endfunction

  function automatic logic signed [19:0] sx(input logic [17:0] p);
    return {{2{p[17]}}, p};
  endfunction

  // Add the three products and the bias, shift out the Q8 fraction, then saturate.
  function automatic logic [7:0] round_clamp(input logic [17:0] a, b, c,
                                             input logic signed [19:0] bias);
    logic signed [19:0] s;
    s = (sx(a) + sx(b) + sx(c) + bias) >>> 8;
    if (s < 20'sd0)        return 8'd0;
    else if (s > 20'sd255) return 8'd255;
    else                   return s[7:0];
  endfunction

  // Scale luma into 0..219; the +16 offset is added in the last stage.
  function automatic logic [7:0] scale_y(input logic [7:0] yf);
    logic [16:0] t;
    t = {9'd0, yf} * 17'd220 + 17'd128;
    return 8'(t >> 8);
  endfunction

  // Centre chroma on zero, scale it into -112..112, then round with an arithmetic shift.
  function automatic logic [8:0] scale_c(input logic [7:0] cf);
    logic signed [17:0] t;
    t = ($signed({10'd0, cf}) - 18'sd128) * 18'sd225 + 18'sd128;
    return 9'(t >>> 8);
  endfunction

  // Mode capture: load only on a ce-qualified rising edge of vsync.
  // The newly loaded mode already applies to the sample that carries the edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path leaves it unassigned, which would infer a latch.
    vs_prev_d   = vs_prev_q;
    std_act_d   = std_act_q;
    range_act_d = range_act_q;
    mode_load   = ce & pre_frame_vsync & ~vs_prev_q;
    std_cur     = mode_load ? std_sel   : std_act_q;
    rng_cur     = mode_load ? range_sel : range_act_q;
    if (ce) begin
      vs_prev_d   = pre_frame_vsync;
      std_act_d   = std_cur;
      range_act_d = rng_cur;
    end
  end

  // S1: expand, then multiply by the coefficients of the active standard.
  always_comb begin
    s1_d = s1_q;
    if (ce) begin
      s1_d.sync = {pre_frame_vsync, pre_frame_hsync, pre_frame_de};
      s1_d.rng  = rng_cur;
      s1_d.yr   = mul(r8, std_cur ? C709_YR : C601_YR);
      s1_d.yg   = mul(g8, std_cur ? C709_YG : C601_YG);
      s1_d.yb   = mul(b8, std_cur ? C709_YB : C601_YB);
      s1_d.br   = mul(r8, std_cur ? C709_BR : C601_BR);
      s1_d.bg   = mul(g8, std_cur ? C709_BG : C601_BG);
      s1_d.bb   = mul(b8, std_cur ? C709_BB : C601_BB);
      s1_d.rr   = mul(r8, std_cur ? C709_RR : C601_RR);
      s1_d.rg   = mul(g8, std_cur ? C709_RG : C601_RG);
      s1_d.rb   = mul(b8, std_cur ? C709_RB : C601_RB);
    end
  end

  // S2: sum, round and clamp to full-range 8-bit values; chroma is biased to 128.
  always_comb begin
    s2_d = s2_q;
    if (ce) begin
      s2_d.sync = s1_q.sync;
      s2_d.rng  = s1_q.rng;
      s2_d.yf   = round_clamp(s1_q.yr, s1_q.yg, s1_q.yb, 20'sd128);
      s2_d.cbf  = round_clamp(s1_q.br, s1_q.bg, s1_q.bb, 20'sd32896);
      s2_d.crf  = round_clamp(s1_q.rr, s1_q.rg, s1_q.rb, 20'sd32896);
    end
  end

  // S3: apply limited-range scaling, or pass full-range values straight through.
  always_comb begin
    s3_d = s3_q;
    if (ce) begin
      s3_d.sync = s2_q.sync;
      s3_d.rng  = s2_q.rng;
      if (s2_q.rng) begin
        s3_d.ys  = scale_y(s2_q.yf);
        s3_d.cbs = scale_c(s2_q.cbf);
        s3_d.crs = scale_c(s2_q.crf);
      end else begin
        s3_d.ys  = s2_q.yf;
        s3_d.cbs = {1'b0, s2_q.cbf};
        s3_d.crs = {1'b0, s2_q.crf};
      end
    end
  end

  // S4: add the limited-range offsets and force the pixel to zero during blanking.
  always_comb begin
    s4_d = s4_q;
    if (ce) begin
      s4_d.sync = s3_q.sync;
      s4_d.y    = 8'd0;
      s4_d.cb   = 8'd0;
      s4_d.cr   = 8'd0;
      if (s3_q.sync[0]) begin
        s4_d.y  = s3_q.rng ? s3_q.ys + 8'd16 : s3_q.ys;
        s4_d.cb = s3_q.rng ? 8'(s3_q.cbs + 9'd128) : s3_q.cbs[7:0];
        s4_d.cr = s3_q.rng ? 8'(s3_q.crs + 9'd128) : s3_q.crs[7:0];
      end
    end
  end

  // State registers: asynchronous reset clears the pipeline, the sync delays and the modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      s4_q        <= '0;
      vs_prev_q   <= 1'b0;
      std_act_q   <= 1'b0;
      range_act_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value on the same edge.
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      s4_q        <= s4_d;
      vs_prev_q   <= vs_prev_d;
      std_act_q   <= std_act_d;
      range_act_q <= range_act_d;
    end
  end

  assign post_frame_vsync = s4_q.sync[2];
  assign post_frame_hsync = s4_q.sync[1];
  assign post_frame_de    = s4_q.sync[0];
  assign img_y            = s4_q.y;
  assign img_cb           = s4_q.cb;
  assign img_cr           = s4_q.cr;
  assign std_act          = std_act_q;
  assign range_act        = range_act_q;

endmodule

// File: tb/tb_rgb2ycbcr_cfg.sv
// Testbench for rgb2ycbcr_cfg.
// A table of hand-derived vectors and a small integer reference model feed a
// scoreboard queue, and sequences cover mode switching, ce stalls, the 8-bit and
// 4-bit width variants and mid-stream reset.
module tb_rgb2ycbcr_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ce, vs, hs, de, std_sel, range_sel;
  logic [4:0] red;
  logic [5:0] green;
  logic [4:0] blue;
  logic       o_vs, o_hs, o_de, o_std, o_rng;
  logic [7:0] o_y, o_cb, o_cr;

  logic [7:0] max8 = 8'hff;
  logic [3:0] max4 = 4'hf;
  logic       o8_vs, o8_hs, o8_de, o8_std, o8_rng;
  logic [7:0] o8_y, o8_cb, o8_cr;
  logic       o4_vs, o4_hs, o4_de, o4_std, o4_rng;
  logic [7:0] o4_y, o4_cb, o4_cr;

  rgb2ycbcr_cfg dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_red(red), .img_green(green), .img_blue(blue),
    .std_sel(std_sel), .range_sel(range_sel),
    .post_frame_vsync(o_vs), .post_frame_hsync(o_hs), .post_frame_de(o_de),
    .img_y(o_y), .img_cb(o_cb), .img_cr(o_cr),
    .std_act(o_std), .range_act(o_rng)
  );

  rgb2ycbcr_cfg #(.R_W(8), .G_W(8), .B_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_red(max8), .img_green(max8), .img_blue(max8),
    .std_sel(std_sel), .range_sel(range_sel),
    .post_frame_vsync(o8_vs), .post_frame_hsync(o8_hs), .post_frame_de(o8_de),
    .img_y(o8_y), .img_cb(o8_cb), .img_cr(o8_cr),
    .std_act(o8_std), .range_act(o8_rng)
  );

  rgb2ycbcr_cfg #(.R_W(4), .G_W(4), .B_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_red(max4), .img_green(max4), .img_blue(max4),
    .std_sel(std_sel), .range_sel(range_sel),
    .post_frame_vsync(o4_vs), .post_frame_hsync(o4_hs), .post_frame_de(o4_de),
    .img_y(o4_y), .img_cb(o4_cb), .img_cr(o4_cr),
    .std_act(o4_std), .range_act(o4_rng)
  );

  typedef struct packed {
    logic       vs, hs, de;
    logic [7:0] y, cb, cr;
  } exp_t;

  typedef struct {
    int   r, g, b;
    logic s, rg;
    int   y, cb, cr;
  } vec_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_chk = 0;
  int   n_pass = 0;
  logic mdl_std, mdl_rng, mdl_vs_prev;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic int expand(input int x, input int w);
    return ((x << (8 - w)) | (x >> (2 * w - 8))) & 255;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  // Integer reference model of the conversion. The inputs use the default 5/6/5 widths.
  function automatic exp_t model(input int r, g, b, input logic s, rg);
    exp_t e;
    int r8, g8, b8, sy, sb, sr, yf, cbf, crf;
    r8 = expand(r, 5); g8 = expand(g, 6); b8 = expand(b, 5);
    if (s) begin
      sy = 54*r8 + 183*g8 + 19*b8;  sb = -29*r8 - 99*g8 + 128*b8; sr = 128*r8 - 116*g8 - 12*b8;
    end else begin
      sy = 77*r8 + 150*g8 + 29*b8;  sb = -43*r8 - 85*g8 + 128*b8; sr = 128*r8 - 107*g8 - 21*b8;
    end
    yf  = clamp((sy + 128) >>> 8);
    cbf = clamp((sb + 32768 + 128) >>> 8);
    crf = clamp((sr + 32768 + 128) >>> 8);
    if (rg) begin
      yf  = 16 + ((yf * 220 + 128) >> 8);
      cbf = 128 + (((cbf - 128) * 225 + 128) >>> 8);
      crf = 128 + (((crf - 128) * 225 + 128) >>> 8);
    end
    e = '0;
    e.y = 8'(yf); e.cb = 8'(cbf); e.cr = 8'(crf);
    return e;
  endfunction

  // Reset view: modes cleared, and the first three outputs after release are all zero.
  task automatic reset_model();
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
    last_exp    = '0;
    mdl_std     = 1'b0;
    mdl_rng     = 1'b0;
    mdl_vs_prev = 1'b0;
  endtask

  // Drives one clock of stimulus. When ce is high it pushes the expected result and
  // pops the result now due at the output. When ce is low the previous output must hold.
  task automatic cyc(input string tag, input logic c, v, h, d, input int r, g, b,
                     input logic s, rg, input logic tab = 1'b0,
                     input int ty = 0, input int tcb = 0, input int tcr = 0);
    exp_t e;
    ce = c; vs = v; hs = h; de = d;
    red = 5'(r); green = 6'(g); blue = 5'(b);
    std_sel = s; range_sel = rg;
    e = '0;
    if (c) begin
      if (v && !mdl_vs_prev) begin
        mdl_std = s;
        mdl_rng = rg;
      end
      mdl_vs_prev = v;
      if (d) begin
        if (tab) begin
          e.y = 8'(ty); e.cb = 8'(tcb); e.cr = 8'(tcr);
        end else begin
          e = model(r, g, b, mdl_std, mdl_rng);
        end
      end
      e.vs = v; e.hs = h; e.de = d;
    end
    @(posedge clk);
    #1;
    if (c) begin
      exp_q.push_back(e);
      last_exp = exp_q.pop_front();
    end
    check({tag, "_pix"}, 32'({o_vs, o_hs, o_de, o_y, o_cb, o_cr}), 32'(last_exp));
    check({tag, "_mode"}, 32'({o_std, o_rng}), 32'({mdl_std, mdl_rng}));
  endtask

  task automatic blank(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, std_sel, range_sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Hand-derived expectations, with R/G/B given in 5/6/5 input widths.
    vecs[0] = '{31, 63, 31, 1'b0, 1'b0, 255, 128, 128}; // white, 601 full
    vecs[1] = '{31,  0,  0, 1'b0, 1'b0,  77,  85, 255}; // red, 601 full, Cr clamps
    vecs[2] = '{31,  0,  0, 1'b1, 1'b0,  54,  99, 255}; // red, 709 full
    vecs[3] = '{31, 63, 31, 1'b0, 1'b1, 235, 128, 128}; // white, limited
    vecs[4] = '{ 0,  0,  0, 1'b0, 1'b1,  16, 128, 128}; // black, limited
    vecs[5] = '{ 0,  0, 31, 1'b0, 1'b1,  41, 240, 110}; // blue, 601 limited
    vecs[6] = '{ 0, 63,  0, 1'b0, 1'b0, 149,  43,  21}; // green, 601 full
    vecs[7] = '{31, 63, 31, 1'b1, 1'b1, 235, 128, 128}; // white, 709 limited

    rst_n = 1'b0; ce = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0;
    red = '0; green = '0; blue = '0; std_sel = 1'b0; range_sel = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pix", 32'({o_vs, o_hs, o_de, o_y, o_cb, o_cr}), 32'd0);
    check("reset_mode", 32'({o_std, o_rng}), 32'd0);
    rst_n = 1'b1;

    // Table vectors: each is a one-pixel frame whose vsync edge selects its mode.
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("vec%0d", i), 1'b1, 1'b1, 1'b1, 1'b1, vecs[i].r, vecs[i].g, vecs[i].b,
          vecs[i].s, vecs[i].rg, 1'b1, vecs[i].y, vecs[i].cb, vecs[i].cr);
      cyc($sformatf("vec%0d_gap", i), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, vecs[i].s, vecs[i].rg);
    end
    blank("flush", 4);

    // A mode change mid-frame is ignored until the next vsync rising edge. Held vsync loads once.
    cyc("m_frame", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc("m_601", 1'b1, 1'b0, 1'b1, 1'b1, $urandom_range(31), $urandom_range(63),
          $urandom_range(31), (i >= 2), 1'b0);
    cyc("m_edge", 1'b1, 1'b1, 1'b0, 1'b1, 31, 0, 0, 1'b1, 1'b0);
    cyc("m_hold1", 1'b1, 1'b1, 1'b0, 1'b1, 31, 0, 0, 1'b0, 1'b1);
    cyc("m_hold2", 1'b1, 1'b1, 1'b0, 1'b1, 0, 63, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      cyc("m_709", 1'b1, 1'b0, 1'b1, 1'b1, $urandom_range(31), $urandom_range(63),
          $urandom_range(31), 1'b0, 1'b1);
    // A vsync rising edge sampled while ce is low must not load a mode.
    cyc("m_ce0edge", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    cyc("m_after", 1'b1, 1'b0, 1'b0, 1'b1, 5, 40, 20, 1'b0, 1'b1);
    blank("m_flush", 4);

    // ce stalls for 3 cycles mid-stream, and de drops periodically for blanking.
    cyc("ce_frame", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++)
      cyc("ce_run", !(i >= 5 && i < 8), 1'b0, (i % 4 == 0), (i % 5 != 4),
          $urandom_range(31), $urandom_range(63), $urandom_range(31), 1'b0, 1'b1);
    blank("ce_flush", 4);

    // Width variants with all-ones inputs: 8-bit and 4-bit builds both give white.
    cyc("sw_frame", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("sw_run", 1'b1, 1'b0, 1'b1, 1'b1, 31, 63, 31, 1'b0, 1'b0);
    check("sweep8_pix", 32'({o8_vs, o8_hs, o8_de, o8_y, o8_cb, o8_cr}),
          32'({last_exp.vs, last_exp.hs, 1'b1, 8'd255, 8'd128, 8'd128}));
    check("sweep4_pix", 32'({o4_vs, o4_hs, o4_de, o4_y, o4_cb, o4_cr}),
          32'({last_exp.vs, last_exp.hs, 1'b1, 8'd255, 8'd128, 8'd128}));
    check("sweep_mode", 32'({o8_std, o8_rng, o4_std, o4_rng}),
          32'({mdl_std, mdl_rng, mdl_std, mdl_rng}));

    // Reset mid-stream clears everything at once, then the pipeline refills from zero.
    cyc("rs_frame", 1'b1, 1'b1, 1'b0, 1'b1, 10, 20, 30, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc("rs_run", 1'b1, 1'b0, 1'b1, 1'b1, 31, 63, 31, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_pix", 32'({o_vs, o_hs, o_de, o_y, o_cb, o_cr}), 32'd0);
    check("rs_mode", 32'({o_std, o_rng, o8_std, o4_std}), 32'd0);
    check("rs_sweep", 32'({o8_de, o8_y, o4_de, o4_y}), 32'd0);
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      cyc("rs_after", 1'b1, (i == 0), 1'b0, 1'b1, $urandom_range(31), $urandom_range(63),
          $urandom_range(31), 1'b0, 1'b0);
    blank("rs_flush", 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
